// File: rtl/chip_host_driver_pkg.sv
// Shared types and constants for the chip host driver: FSM states,
// the 7-segment patterns for nibbles 0..F, and the response error codes.
// Imported by the decoder and the driver top.
package chip_host_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SETTLE,
    ST_WAIT,
    ST_SAMPLE
  } state_t;

  // Segment patterns, bit order {g,f,e,d,c,b,a}, bit 7 always 0.
  localparam logic [7:0] SEG_0 = 8'h3F;
  localparam logic [7:0] SEG_1 = 8'h06;
  localparam logic [7:0] SEG_2 = 8'h5B;
  localparam logic [7:0] SEG_3 = 8'h4F;
  localparam logic [7:0] SEG_4 = 8'h66;
  localparam logic [7:0] SEG_5 = 8'h6D;
  localparam logic [7:0] SEG_6 = 8'h7D;
  localparam logic [7:0] SEG_7 = 8'h07;
  localparam logic [7:0] SEG_8 = 8'h7F;
  localparam logic [7:0] SEG_9 = 8'h6F;
  localparam logic [7:0] SEG_A = 8'h77;
  localparam logic [7:0] SEG_B = 8'h7C;
  localparam logic [7:0] SEG_C = 8'h39;
  localparam logic [7:0] SEG_D = 8'h5E;
  localparam logic [7:0] SEG_E = 8'h79;
  localparam logic [7:0] SEG_F = 8'h71;

  localparam logic [1:0] ERR_OK       = 2'd0;
  localparam logic [1:0] ERR_PATTERN  = 2'd1;
  localparam logic [1:0] ERR_CONFLICT = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

endpackage

// File: rtl/chip_host_driver_if.sv
// Host-side instruction/response handshake plus the chip pin bundle.
// slave = the driver block, master = whoever feeds words and models the chip.
// Carries no state; pure wiring.
interface chip_host_driver_if;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic        chip_ena;
  logic [7:0]  chip_ui_in;
  logic [7:0]  chip_uio_in;
  logic [7:0]  chip_uo_out;
  logic [7:0]  chip_uio_oe;
  logic        rsp_valid;
  logic [3:0]  rsp_data;
  logic [1:0]  rsp_err;

  modport slave (
    input  instr_valid, instr, chip_uo_out, chip_uio_oe,
    output instr_ready, chip_ena, chip_ui_in, chip_uio_in,
           rsp_valid, rsp_data, rsp_err
  );

  modport master (
    output instr_valid, instr, chip_uo_out, chip_uio_oe,
    input  instr_ready, chip_ena, chip_ui_in, chip_uio_in,
           rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/chip_host_driver_seg7_decode.sv
// Inverse of the chip's segment encoder: pattern -> nibble plus valid flag.
// Purely combinational, zero latency.
// No flow control; patterns with bit 7 set never match and decode as invalid.
module seg7_decode
  import chip_host_pkg::*;
(
  input  logic [7:0] pattern,
  output logic [3:0] nibble,
  output logic       valid
);

  // Table lookup; anything outside the 16 legal patterns is flagged invalid.
  always_comb begin
    nibble = 4'h0;
    valid  = 1'b1;
    case (pattern)
      SEG_0:   nibble = 4'h0;
      SEG_1:   nibble = 4'h1;
      SEG_2:   nibble = 4'h2;
      SEG_3:   nibble = 4'h3;
      SEG_4:   nibble = 4'h4;
      SEG_5:   nibble = 4'h5;
      SEG_6:   nibble = 4'h6;
      SEG_7:   nibble = 4'h7;
      SEG_8:   nibble = 4'h8;
      SEG_9:   nibble = 4'h9;
      SEG_A:   nibble = 4'hA;
      SEG_B:   nibble = 4'hB;
      SEG_C:   nibble = 4'hC;
      SEG_D:   nibble = 4'hD;
      SEG_E:   nibble = 4'hE;
      SEG_F:   nibble = 4'hF;
      default: valid  = 1'b0;
    endcase
  end

endmodule

// File: rtl/chip_host_driver.sv
// Host sequencer: drives a 16-bit word onto the chip pins, waits for the segment bus to settle, returns the decoded nibble.
// Latency accept->rsp_valid = 1 + SETTLE_CYCLES + STABLE_CYCLES + 1 cycles; optional WAIT_STABLE expiry under HOST_DRV_TIMEOUT_EN.
// Backpressure: instr_ready high only in IDLE; words offered while busy are not captured.
module chip_host_driver
  import chip_host_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 2,
  parameter int STABLE_CYCLES  = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic               clk,
  input logic               rst_n,
  chip_host_driver_if.slave bus
);

  state_t     state;
  logic [3:0] settle_cnt;
  logic [2:0] stable_cnt;
  logic [7:0] prev;
  logic       conflict;
  logic [3:0] dec_nibble;
  logic       dec_ok;
  logic       oe_hit;
  logic       stable_done;
  logic       timeout_hit;
  logic       timed_out;
  logic [1:0] err_next;

  seg7_decode u_dec (
    .pattern (prev),
    .nibble  (dec_nibble),
    .valid   (dec_ok)
  );

  assign oe_hit      = |bus.chip_uio_oe;
  assign stable_done = (bus.chip_uo_out == prev) && (stable_cnt == 3'(STABLE_CYCLES - 1));

`ifdef HOST_DRV_TIMEOUT_EN
  logic [7:0] tmo_cnt;

  assign timeout_hit = (tmo_cnt == 8'(TIMEOUT_CYCLES - 1));

  // Count WAIT_STABLE cycles and remember whether the wait ended by expiry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt   <= 8'd0;
      timed_out <= 1'b0;
    end else if (state == ST_SETTLE) begin
      tmo_cnt   <= 8'd0;
      timed_out <= 1'b0;
    end else if (state == ST_WAIT) begin
      tmo_cnt <= tmo_cnt + 8'd1;
      if (timeout_hit && !stable_done) timed_out <= 1'b1;
    end
  end
`else
  logic unused_tmo;

  assign timeout_hit = 1'b0;
  assign timed_out   = 1'b0;
  assign unused_tmo  = ^8'(TIMEOUT_CYCLES);
`endif

  // Error priority: timeout over bus conflict over undecodable pattern.
  always_comb begin
    err_next = ERR_OK;
    if (timed_out)              err_next = ERR_TIMEOUT;
    else if (conflict || oe_hit) err_next = ERR_CONFLICT;
    else if (!dec_ok)           err_next = ERR_PATTERN;
  end

  // Transaction sequencer with registered pin and response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_IDLE;
      settle_cnt      <= 4'd0;
      stable_cnt      <= 3'd0;
      prev            <= 8'd0;
      conflict        <= 1'b0;
      bus.instr_ready <= 1'b1;
      bus.chip_ena    <= 1'b0;
      bus.chip_ui_in  <= 8'd0;
      bus.chip_uio_in <= 8'd0;
      bus.rsp_valid   <= 1'b0;
      bus.rsp_data    <= 4'd0;
      bus.rsp_err     <= ERR_OK;
    end else begin
      bus.rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.instr_valid) begin
            bus.chip_ui_in  <= bus.instr[7:0];
            bus.chip_uio_in <= bus.instr[15:8];
            bus.chip_ena    <= 1'b1;
            bus.instr_ready <= 1'b0;
            conflict        <= 1'b0;
            state           <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          if (oe_hit) conflict <= 1'b1;
          settle_cnt <= 4'(SETTLE_CYCLES);
          state      <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (oe_hit) conflict <= 1'b1;
          if (settle_cnt == 4'd1) begin
            stable_cnt <= 3'd0;
            prev       <= bus.chip_uo_out;
            state      <= ST_WAIT;
          end else begin
            settle_cnt <= settle_cnt - 4'd1;
          end
        end
        ST_WAIT: begin
          if (oe_hit) conflict <= 1'b1;
          if (stable_done || timeout_hit) begin
            state <= ST_SAMPLE;
          end else if (bus.chip_uo_out == prev) begin
            stable_cnt <= stable_cnt + 3'd1;
          end else begin
            stable_cnt <= 3'd0;
            prev       <= bus.chip_uo_out;
          end
        end
        ST_SAMPLE: begin
          bus.rsp_valid   <= 1'b1;
          bus.rsp_err     <= err_next;
          bus.rsp_data    <= (err_next == ERR_OK) ? dec_nibble : 4'd0;
          bus.chip_ena    <= 1'b0;
          bus.instr_ready <= 1'b1;
          conflict        <= 1'b0;
          state           <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
